// File: rtl/seq_divider_pkg.sv
// Shared types and sizing for the sequential signed divider.
package seq_divider_pkg;

    localparam int unsigned DIV_WIDTH = 32;
    localparam int unsigned DIV_ITERS = 32;
    localparam int unsigned REM_WIDTH = DIV_WIDTH + 1;
    localparam int unsigned CNT_WIDTH = 6;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } state_t;

    // Two's-complement magnitude; -2^31 maps to 32'h8000_0000 read as unsigned.
    function automatic logic [DIV_WIDTH-1:0] abs_val(input logic [DIV_WIDTH-1:0] x);
        return x[DIV_WIDTH-1] ? DIV_WIDTH'(-x) : x;
    endfunction

endpackage

// File: rtl/seq_divider_add_sub_33.sv
// 33-bit parallel-prefix carry-lookahead adder with subtract control.
module add_sub_33
    import seq_divider_pkg::*;
(
    input  logic [REM_WIDTH-1:0] a,
    input  logic [REM_WIDTH-1:0] b,
    input  logic                 sub,
    output logic [REM_WIDTH-1:0] sum
);

    logic [REM_WIDTH-1:0] bx;
    logic [REM_WIDTH-1:0] g;
    logic [REM_WIDTH-1:0] p;
    logic [REM_WIDTH-1:0] gg;
    logic [REM_WIDTH-1:0] pp;
    logic [REM_WIDTH-1:0] c;

    always_comb begin
        bx = b ^ {REM_WIDTH{sub}};
        g  = a & bx;
        p  = a ^ bx;
        gg = g;
        pp = p;
        // Kogge-Stone prefix; descending index keeps gg[i-d] at the previous stage value
        for (int d = 1; d < int'(REM_WIDTH); d = d * 2) begin
            for (int i = int'(REM_WIDTH) - 1; i >= d; i--) begin
                gg[i] = gg[i] | (pp[i] & gg[i-d]);
                pp[i] = pp[i] & pp[i-d];
            end
        end
        c[0] = sub;
        for (int i = 1; i < int'(REM_WIDTH); i++) begin
            c[i] = gg[i-1] | (pp[i-1] & sub);
        end
        sum = p ^ c;
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed divider: 32 non-restoring iterations on magnitudes, then sign fix-up.
module seq_divider
    import seq_divider_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [DIV_WIDTH-1:0] dividend,
    input  logic [DIV_WIDTH-1:0] divisor,
    output logic                 busy,
    output logic                 done,
    output logic [DIV_WIDTH-1:0] quotient,
    output logic [DIV_WIDTH-1:0] remainder,
    output logic                 div_zero
);

    state_t               state;
    logic [CNT_WIDTH-1:0] cnt;
    logic [REM_WIDTH-1:0] rem;
    logic [DIV_WIDTH-1:0] quo;
    logic [DIV_WIDTH-1:0] dmag;
    logic                 neg_q;
    logic                 neg_r;
    logic                 dz_pend;

    logic [REM_WIDTH-1:0] rem_sh;
    logic [REM_WIDTH-1:0] add_a;
    logic [REM_WIDTH-1:0] add_b;
    logic [REM_WIDTH-1:0] add_sum;
    logic                 add_sub;
    logic [DIV_WIDTH-1:0] rem_fix;
    logic [DIV_WIDTH-1:0] q_final;
    logic [DIV_WIDTH-1:0] r_final;

    assign rem_sh = {rem[DIV_WIDTH-1:0], quo[DIV_WIDTH-1]};

    // One adder serves both the iteration step and the final remainder restore.
    always_comb begin
        add_a   = rem_sh;
        add_b   = {1'b0, dmag};
        add_sub = ~rem[REM_WIDTH-1];
        if (state == FIX) begin
            add_a   = rem;
            add_sub = 1'b0;
        end
    end

    add_sub_33 u_add_sub (
        .a   (add_a),
        .b   (add_b),
        .sub (add_sub),
        .sum (add_sum)
    );

    assign rem_fix = rem[REM_WIDTH-1] ? add_sum[DIV_WIDTH-1:0] : rem[DIV_WIDTH-1:0];
    assign q_final = neg_q ? DIV_WIDTH'(-quo) : quo;
    assign r_final = neg_r ? DIV_WIDTH'(-rem_fix) : rem_fix;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            rem       <= '0;
            quo       <= '0;
            dmag      <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            dz_pend   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // busy still high here means this is the done cycle: drop busy, ignore start
                    if (busy) begin
                        busy <= 1'b0;
                    end else if (start) begin
                        busy  <= 1'b1;
                        neg_q <= dividend[DIV_WIDTH-1] ^ divisor[DIV_WIDTH-1];
                        neg_r <= dividend[DIV_WIDTH-1];
                        dmag  <= abs_val(divisor);
                        cnt   <= '0;
                        if (divisor == '0) begin
                            quo     <= '1;
                            rem     <= {1'b0, dividend};
                            dz_pend <= 1'b1;
                            state   <= DONE;
                        end else begin
                            quo     <= abs_val(dividend);
                            rem     <= '0;
                            dz_pend <= 1'b0;
                            state   <= RUN;
                        end
                    end
                end
                RUN: begin
                    rem <= add_sum;
                    quo <= {quo[DIV_WIDTH-2:0], ~add_sum[REM_WIDTH-1]};
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_WIDTH'(DIV_ITERS - 1)) begin
                        cnt   <= '0;
                        state <= FIX;
                    end
                end
                FIX: begin
                    rem   <= {1'b0, r_final};
                    quo   <= q_final;
                    state <= DONE;
                end
                DONE: begin
                    done      <= 1'b1;
                    quotient  <= quo;
                    remainder <= rem[DIV_WIDTH-1:0];
                    div_zero  <= dz_pend;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider against a plain-arithmetic division model.
module tb_seq_divider;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_zero;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    seq_divider dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    // Signed division truncating toward zero; 64-bit math covers -2^31 / -1.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r,
                                  output logic dz, output int lat);
        longint sa;
        longint sb;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF; r = a; dz = 1'b1; lat = 1;
        end else begin
            sa = longint'(signed'(a));
            sb = longint'(signed'(b));
            q = 32'(sa / sb); r = 32'(sa % sb); dz = 1'b0; lat = 34;
        end
    endfunction

    // Called #1 after a posedge; returns once done is seen or the budget runs out.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] q, output logic [31:0] r,
                          output logic dz, output int lat, output logic busy_ok);
        dividend = a; divisor = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; dividend = $urandom; divisor = $urandom;
        lat = 0;
        busy_ok = (busy === 1'b1);
        while (done !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (busy !== 1'b1) busy_ok = 1'b0;
        end
        q = quotient; r = remainder; dz = div_zero;
    endtask

    task automatic check_op(input string name, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q, r, eq, er;
        logic dz, edz, bok;
        int lat, elat;
        model(a, b, eq, er, edz, elat);
        run_op(a, b, q, r, dz, lat, bok);
        n_tests++;
        if (lat !== elat) begin
            n_fail++; $display("FAIL %s latency %h/%h: got %0d want %0d", name, a, b, lat, elat);
        end
        n_tests++;
        if ({q, r, dz} !== {eq, er, edz}) begin
            n_fail++;
            $display("FAIL %s result %h/%h: got q=%h r=%h dz=%b want q=%h r=%h dz=%b",
                     name, a, b, q, r, dz, eq, er, edz);
        end
        n_tests++;
        if (bok !== 1'b1) begin
            n_fail++; $display("FAIL %s busy %h/%h: got busy low before/at done, want high", name, a, b);
        end
        @(posedge clk); #1;
        n_tests++;
        if ({done, busy} !== 2'b00) begin
            n_fail++; $display("FAIL %s tail %h/%h: got done,busy=%b%b want 00", name, a, b, done, busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
        #12;
        n_tests++;
        if ({busy, done, div_zero, quotient, remainder} !== 67'd0) begin
            n_fail++;
            $display("FAIL reset_state: got busy=%b done=%b dz=%b q=%h r=%h want all 0",
                     busy, done, div_zero, quotient, remainder);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [31:0] ta[7] = '{32'd100, -32'sd100, 32'd100, 32'd5, 32'h8000_0000, 32'd0, 32'h7FFF_FFFF};
        logic [31:0] tb[7] = '{32'd7, 32'd7, -32'sd7, 32'd0, 32'hFFFF_FFFF, 32'd9, 32'd1};
        for (int i = 0; i < 7; i++) check_op("directed", ta[i], tb[i]);
        n_tests++;
        if (quotient !== 32'h7FFF_FFFF) begin
            n_fail++; $display("FAIL directed_last: got q=%h want 7fffffff", quotient);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b;
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1, 2:    b = 32'($signed($urandom_range(0, 40)) - 20);
                3:       a = 32'($signed($urandom_range(0, 2000)) - 1000);
                default: b = $urandom;
            endcase
            if (i == 0) b = 32'd1;
            check_op("random", a, b);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] eq, er;
        logic edz;
        int elat, lat;
        model(32'd1000, -32'sd13, eq, er, edz, elat);
        dividend = 32'd1000; divisor = -32'sd13; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; lat = 0;
        while (done !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 9) begin
                dividend = 32'd77; divisor = 32'd5; start = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        n_tests++;
        if (lat !== 34 || {quotient, remainder, div_zero} !== {eq, er, edz}) begin
            n_fail++;
            $display("FAIL busy_ignore: got lat=%0d q=%h r=%h dz=%b want lat=34 q=%h r=%h dz=%b",
                     lat, quotient, remainder, div_zero, eq, er, edz);
        end
        // start during the done cycle must be dropped as well
        dividend = 32'd5; divisor = 32'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_tests++;
        if ({busy, done} !== 2'b00) begin
            n_fail++; $display("FAIL done_cycle_start: got busy,done=%b%b want 00", busy, done);
        end
        @(posedge clk); #1;
        n_tests++;
        if ({busy, done, quotient, remainder, div_zero} !== {2'b00, eq, er, edz}) begin
            n_fail++;
            $display("FAIL done_cycle_hold: got busy=%b done=%b q=%h r=%h dz=%b want busy=0 done=0 q=%h r=%h dz=%b",
                     busy, done, quotient, remainder, div_zero, eq, er, edz);
        end
    endtask

    task automatic test_hold();
        logic [31:0] eq, er;
        logic edz, ok;
        int elat;
        check_op("hold_setup", -32'sd12345, 32'd17);
        model(-32'sd12345, 32'd17, eq, er, edz, elat);
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            dividend = $urandom; divisor = $urandom;
            @(posedge clk); #1;
            if ({quotient, remainder, div_zero} !== {eq, er, edz}) ok = 1'b0;
        end
        dividend = 32'd50; divisor = 32'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // zero-divisor op is accepted; its result appears only after E1
        n_tests++;
        if (ok !== 1'b1 || {quotient, remainder, div_zero} !== {eq, er, edz}) begin
            n_fail++;
            $display("FAIL hold_idle: got q=%h r=%h dz=%b want q=%h r=%h dz=%b",
                     quotient, remainder, div_zero, eq, er, edz);
        end
        @(posedge clk); #1;
        n_tests++;
        if ({done, div_zero, quotient, remainder} !== {2'b11, 32'hFFFF_FFFF, 32'd50}) begin
            n_fail++;
            $display("FAIL hold_zero_div: got done=%b dz=%b q=%h r=%h want done=1 dz=1 q=ffffffff r=00000032",
                     done, div_zero, quotient, remainder);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_midrun();
        logic seen;
        check_op("rst_setup", 32'd7, 32'd0);
        dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({busy, done, div_zero, quotient, remainder} !== 67'd0) begin
            n_fail++;
            $display("FAIL reset_midrun: got busy=%b done=%b dz=%b q=%h r=%h want all 0",
                     busy, done, div_zero, quotient, remainder);
        end
        #2 rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        n_tests++;
        if (seen !== 1'b0) begin
            n_fail++; $display("FAIL reset_no_done: got done/busy activity after reset, want none");
        end
        check_op("after_reset", 32'd9, 32'd3);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_hold();
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
